// File: rtl/timer_regs_ctrl_pkg.sv
// Shared definitions for the DMG timer register block: register offsets,
// FSM states and TAC tap-select codes.
package timer_regs_ctrl_pkg;

  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RELOAD  = 2'd2
  } timer_state_e;

  typedef enum logic [1:0] {
    TAP_CNT7 = 2'b00,
    TAP_CNT1 = 2'b01,
    TAP_CNT3 = 2'b10,
    TAP_CNT5 = 2'b11
  } tap_sel_e;

  function automatic logic tapBit(input logic [7:0] cntLow, input tap_sel_e sel);
    case (sel)
      TAP_CNT7: return cntLow[7];
      TAP_CNT1: return cntLow[1];
      TAP_CNT3: return cntLow[3];
      default:  return cntLow[5];
    endcase
  endfunction

endpackage

// File: rtl/timer_regs_ctrl_if.sv
// CPU-side memory bus for the timer register block.
interface timer_regs_ctrl_if;
  logic [15:0] mcuAddr;
  logic        mcuWe;
  logic [7:0]  mcuWriteData;
  logic [7:0]  mcuReadData;
  logic        mcuHit;

  modport master (output mcuAddr, mcuWe, mcuWriteData, input mcuReadData, mcuHit);
  modport slave  (input mcuAddr, mcuWe, mcuWriteData, output mcuReadData, mcuHit);
endinterface

// File: rtl/timer_edge_select.sv
// TAC tap mux plus falling-edge detector producing the TIMA increment pulse.
// TIMER_DIV_GLITCH_EN: falls caused by DIV/TAC writes also increment TIMA.
module timer_edge_select import timer_regs_ctrl_pkg::*; (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iTick,
  input  logic [7:0] iCntLow,
  input  logic [2:0] iTacNext,
  input  logic       iResync,
  output logic       oInc
);
  logic timerIn, timerInQ, fall;

  // Edge register follows the next-state timer input every clock, so the
  // non-glitch build resyncs simply by masking write-induced falls.
  assign timerIn = iTacNext[2] & tapBit(iCntLow, tap_sel_e'(iTacNext[1:0]));
  assign fall    = timerInQ & ~timerIn;

`ifdef TIMER_DIV_GLITCH_EN
  assign oInc = fall & (iTick | iResync);
`else
  assign oInc = fall & iTick & ~iResync;
`endif

  always_ff @(posedge iClock or posedge iReset)
    if (iReset) timerInQ <= 1'b0;
    else        timerInQ <= timerIn;

endmodule

// File: rtl/timer_regs_ctrl.sv
// DMG timer: DIV/TIMA/TMA/TAC registers, bus decode and overflow/reload FSM.
// Optional macro TIMER_DIV_GLITCH_EN enables write-induced TIMA increments.
module timer_regs_ctrl import timer_regs_ctrl_pkg::*; #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter int          SYS_CNT_W = 14
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iTick,
  timer_regs_ctrl_if.slave bus,
  output logic             oInterrupt0x50
);
  logic [SYS_CNT_W-1:0] sysCnt, sysCntNext;
  logic [7:0]  tima, timaNext, timaBase, tma, tmaNext;
  logic [2:0]  tac, tacNext;
  logic [15:0] offset;
  logic [1:0]  regSel;
  logic        divWr, timaWr, tmaWr, tacWr, timerInc, irqNext;
  timer_state_e state, stateNext;

  assign offset     = bus.mcuAddr - BASE_ADDR;
  assign bus.mcuHit = (offset[15:2] == 14'd0);
  assign regSel     = offset[1:0];
  assign divWr  = bus.mcuWe & bus.mcuHit & (regSel == REG_DIV);
  assign timaWr = bus.mcuWe & bus.mcuHit & (regSel == REG_TIMA);
  assign tmaWr  = bus.mcuWe & bus.mcuHit & (regSel == REG_TMA);
  assign tacWr  = bus.mcuWe & bus.mcuHit & (regSel == REG_TAC);

  assign sysCntNext = divWr ? '0 : sysCnt + SYS_CNT_W'(iTick);
  assign tacNext    = tacWr ? bus.mcuWriteData[2:0] : tac;
  assign tmaNext    = tmaWr ? bus.mcuWriteData : tma;

  always_comb begin
    bus.mcuReadData = 8'hFF;
    if (bus.mcuHit)
      case (regSel)
        REG_DIV:  bus.mcuReadData = sysCnt[SYS_CNT_W-1 -: 8];
        REG_TIMA: bus.mcuReadData = tima;
        REG_TMA:  bus.mcuReadData = tma;
        default:  bus.mcuReadData = {5'b11111, tac};
      endcase
  end

  timer_edge_select uEdge (
    .iClock   (iClock),
    .iReset   (iReset),
    .iTick    (iTick),
    .iCntLow  (sysCntNext[7:0]),
    .iTacNext (tacNext),
    .iResync  (divWr | tacWr),
    .oInc     (timerInc)
  );

  always_comb begin
    stateNext = state;
    timaNext  = tima;
    timaBase  = tima;
    irqNext   = 1'b0;
    case (state)
      ST_IDLE:
        if (timaWr) timaNext = bus.mcuWriteData;
        else if (timerInc) begin
          if (tima == 8'hFF) begin
            timaNext  = 8'h00;
            stateNext = ST_PENDING;
          end else timaNext = tima + 8'd1;
        end
      ST_PENDING:
        if (timaWr) begin
          timaNext  = bus.mcuWriteData;
          stateNext = ST_IDLE;
        end else if (iTick) begin
          timaNext  = tmaNext;
          irqNext   = 1'b1;
          stateNext = ST_RELOAD;
        end
      ST_RELOAD: begin
        // TIMA writes are dropped here; a TMA write lands in both registers.
        timaBase = tmaWr ? bus.mcuWriteData : tima;
        if (iTick) stateNext = ST_IDLE;
        if (timerInc && timaBase == 8'hFF) begin
          timaNext  = 8'h00;
          stateNext = ST_PENDING;
        end else timaNext = timaBase + {7'd0, timerInc};
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset)
    if (iReset) begin
      sysCnt         <= '0;
      tima           <= 8'h00;
      tma            <= 8'h00;
      tac            <= 3'b000;
      state          <= ST_IDLE;
      oInterrupt0x50 <= 1'b0;
    end else begin
      sysCnt         <= sysCntNext;
      tima           <= timaNext;
      tma            <= tmaNext;
      tac            <= tacNext;
      state          <= stateNext;
      oInterrupt0x50 <= irqNext;
    end

endmodule

// File: tb/tb_timer_regs_ctrl.sv
// Bench for timer_regs_ctrl: directed vector table, reset corner case, then
// randomized traffic checked against a behavioural register model.
module tb_timer_regs_ctrl;
  logic iClock = 1'b0;
  logic iReset, iTick, oInterrupt0x50;
  int   nChecks = 0, nFails = 0;

  timer_regs_ctrl_if bus();

  timer_regs_ctrl dut (
    .iClock         (iClock),
    .iReset         (iReset),
    .iTick          (iTick),
    .bus            (bus),
    .oInterrupt0x50 (oInterrupt0x50)
  );

  always #5 iClock = ~iClock;

  task automatic check(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  // Reference model: plain integers, timer input derived straight from counter bits.
  int mCnt, mTima, mTma, mTac, mPhase;
  bit mIrq;
  localparam int PH_NONE = 0, PH_WAIT = 1, PH_RELOAD = 2;

  task automatic mReset();
    mCnt = 0; mTima = 0; mTma = 0; mTac = 0; mPhase = PH_NONE; mIrq = 0;
  endtask

  function automatic bit timerIn(int cnt, int tac);
    int pos;
    case (tac & 3)
      0: pos = 7;
      1: pos = 1;
      2: pos = 3;
      default: pos = 5;
    endcase
    return ((tac >> 2) & 1) == 1 && ((cnt >> pos) & 1) == 1;
  endfunction

  function automatic int mRead(int a);
    case (a)
      'hFF04:  return (mCnt >> 6) & 255;
      'hFF05:  return mTima;
      'hFF06:  return mTma;
      'hFF07:  return 'hF8 | mTac;
      default: return 'hFF;
    endcase
  endfunction

  task automatic mStep(bit tk, bit we, int a, int d);
    bit divW, timaW, tmaW, tacW, bump;
    int nCnt, nTac, nTma, base;
    divW = we && a == 'hFF04;
    timaW = we && a == 'hFF05;
    tmaW = we && a == 'hFF06;
    tacW = we && a == 'hFF07;
    nCnt = divW ? 0 : (mCnt + (tk ? 1 : 0)) % 16384;
    nTac = tacW ? (d & 7) : mTac;
    nTma = tmaW ? d : mTma;
    bump = timerIn(mCnt, mTac) && !timerIn(nCnt, nTac);
`ifdef TIMER_DIV_GLITCH_EN
    bump = bump && (tk || divW || tacW);
`else
    bump = bump && tk && !(divW || tacW);
`endif
    mIrq = 0;
    if (mPhase == PH_WAIT) begin
      if (timaW) begin mTima = d; mPhase = PH_NONE; end
      else if (tk) begin mTima = nTma; mIrq = 1; mPhase = PH_RELOAD; end
    end else begin
      base = mTima;
      if (mPhase == PH_RELOAD) begin
        if (tmaW) base = d;
        if (tk) mPhase = PH_NONE;
      end else if (timaW) begin
        base = d; bump = 0;
      end
      if (bump) begin
        base++;
        if (base == 256) begin base = 0; mPhase = PH_WAIT; end
      end
      mTima = base;
    end
    mCnt = nCnt; mTac = nTac; mTma = nTma;
  endtask

  task automatic cyc(bit tk, bit we, logic [15:0] a, logic [7:0] d);
    iTick = tk; bus.mcuWe = we; bus.mcuAddr = a; bus.mcuWriteData = d;
    @(posedge iClock);
    mStep(tk, we, int'(a), int'(d));
    #1;
    iTick = 1'b0; bus.mcuWe = 1'b0;
  endtask

  task automatic checkRegs(string tag);
    for (int i = 0; i < 4; i++) begin
      bus.mcuAddr = 16'hFF04 + 16'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), int'(bus.mcuReadData), mRead('hFF04 + i));
    end
    check({tag, "_irq"}, int'(oInterrupt0x50), int'(mIrq));
  endtask

  typedef struct {
    string       name;
    bit          tk;
    bit          we;
    logic [15:0] a;
    logic [7:0]  d;
    int          reps;
    logic [15:0] ra;
    logic [7:0]  expRd;
    bit          expHit;
    bit          expIrq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string n, bit tk, bit we, logic [15:0] a, logic [7:0] d, int reps,
                     logic [15:0] ra, logic [7:0] e, bit irq);
    vec_t v;
    v.name = n; v.tk = tk; v.we = we; v.a = a; v.d = d; v.reps = reps;
    v.ra = ra; v.expRd = e; v.expIrq = irq;
    v.expHit = (ra >= 16'hFF04) && (ra <= 16'hFF07);
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] glitchTima;
    iReset = 1'b1; iTick = 1'b0;
    bus.mcuAddr = 16'h0000; bus.mcuWe = 1'b0; bus.mcuWriteData = 8'h00;
    mReset();
    repeat (2) @(posedge iClock);
    #3 iReset = 1'b0;

`ifdef TIMER_DIV_GLITCH_EN
    glitchTima = 8'hAC;
`else
    glitchTima = 8'hAB;
`endif
    add("rst_div",  0, 0, 16'h0000, 8'h00, 0, 16'hFF04, 8'h00, 0);
    add("rst_tima", 0, 0, 16'h0000, 8'h00, 0, 16'hFF05, 8'h00, 0);
    add("rst_tma",  0, 0, 16'h0000, 8'h00, 0, 16'hFF06, 8'h00, 0);
    add("rst_tac",  0, 0, 16'h0000, 8'h00, 0, 16'hFF07, 8'hF8, 0);
    add("offmap",   0, 0, 16'h0000, 8'h00, 1, 16'hFF08, 8'hFF, 0);
    add("tac_wr",   0, 1, 16'hFF07, 8'h05, 1, 16'hFF07, 8'hFD, 0);
    add("tick16",   1, 0, 16'h0000, 8'h00, 16, 16'hFF05, 8'h04, 0);
    add("div_16",   0, 0, 16'h0000, 8'h00, 0, 16'hFF04, 8'h00, 0);
    add("div_64",   1, 0, 16'h0000, 8'h00, 48, 16'hFF04, 8'h01, 0);
    add("tima_64",  0, 0, 16'h0000, 8'h00, 0, 16'hFF05, 8'h10, 0);
    add("div_clr",  0, 1, 16'hFF04, 8'h5A, 1, 16'hFF04, 8'h00, 0);
    add("tma_ab",   0, 1, 16'hFF06, 8'hAB, 1, 16'hFF06, 8'hAB, 0);
    add("tima_ff",  0, 1, 16'hFF05, 8'hFF, 1, 16'hFF05, 8'hFF, 0);
    add("pre_ovf",  1, 0, 16'h0000, 8'h00, 3, 16'hFF05, 8'hFF, 0);
    add("ovf",      1, 0, 16'h0000, 8'h00, 1, 16'hFF05, 8'h00, 0);
    add("reload",   1, 0, 16'h0000, 8'h00, 1, 16'hFF05, 8'hAB, 1);
    add("irq_once", 1, 0, 16'h0000, 8'h00, 1, 16'hFF05, 8'hAB, 0);
    add("p_ff",     0, 1, 16'hFF05, 8'hFF, 1, 16'hFF05, 8'hFF, 0);
    add("p_ovf",    1, 0, 16'h0000, 8'h00, 2, 16'hFF05, 8'h00, 0);
    add("p_wr",     0, 1, 16'hFF05, 8'h55, 1, 16'hFF05, 8'h55, 0);
    add("p_noirq",  1, 0, 16'h0000, 8'h00, 1, 16'hFF05, 8'h55, 0);
    add("r_ff",     0, 1, 16'hFF05, 8'hFF, 1, 16'hFF05, 8'hFF, 0);
    add("r_ovf",    1, 0, 16'h0000, 8'h00, 3, 16'hFF05, 8'h00, 0);
    add("r_reload", 1, 0, 16'h0000, 8'h00, 1, 16'hFF05, 8'hAB, 1);
    add("r_wr_ign", 0, 1, 16'hFF05, 8'h55, 1, 16'hFF05, 8'hAB, 0);
    add("r_idle",   1, 0, 16'h0000, 8'h00, 1, 16'hFF05, 8'hAB, 0);
    add("glitch",   0, 1, 16'hFF04, 8'h00, 1, 16'hFF05, glitchTima, 0);
    add("div_tick", 1, 1, 16'hFF04, 8'h00, 1, 16'hFF04, 8'h00, 0);
    add("div_63",   1, 0, 16'h0000, 8'h00, 63, 16'hFF04, 8'h00, 0);
    add("div_64b",  1, 0, 16'h0000, 8'h00, 1, 16'hFF04, 8'h01, 0);

    foreach (vecs[i]) begin
      repeat (vecs[i].reps) cyc(vecs[i].tk, vecs[i].we, vecs[i].a, vecs[i].d);
      bus.mcuAddr = vecs[i].ra;
      #1;
      check({vecs[i].name, "_rd"}, int'(bus.mcuReadData), int'(vecs[i].expRd));
      check({vecs[i].name, "_hit"}, int'(bus.mcuHit), int'(vecs[i].expHit));
      check({vecs[i].name, "_irq"}, int'(oInterrupt0x50), int'(vecs[i].expIrq));
    end

    // Reset while the overflow is pending must abort it without an interrupt.
    cyc(0, 1, 16'hFF04, 8'h00);
    cyc(0, 1, 16'hFF05, 8'hFF);
    repeat (4) cyc(1, 0, 16'h0000, 8'h00);
    bus.mcuAddr = 16'hFF05;
    #1 check("rstp_pending", int'(bus.mcuReadData), 'h00);
    @(posedge iClock);
    #2 iReset = 1'b1;
    mReset();
    #1 checkRegs("rstp_async");
    iTick = 1'b1;
    repeat (2) @(posedge iClock);
    #3 iReset = 1'b0;
    iTick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 16'h0000, 8'h00);
      checkRegs("rstp_after");
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit tk, we;
      logic [15:0] a;
      logic [7:0] d;
      int sel;
      tk  = $urandom_range(0, 99) < 70;
      we  = $urandom_range(0, 99) < 15;
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 16'hFF04 + 16'(sel);
      else if (sel == 4) a = 16'hFF03;
      else if (sel == 5) a = 16'hFF08;
      else if (sel < 8)  a = 16'hFF05;
      else               a = 16'($urandom);
      d = 8'($urandom);
      if (a == 16'hFF05 || a == 16'hFF06)
        if ($urandom_range(0, 1) == 1) d = 8'($urandom_range(8'hF8, 8'hFF));
      if (a == 16'hFF07 && $urandom_range(0, 3) != 0) d[2] = 1'b1;
      cyc(tk, we, a, d);
      checkRegs("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
